// File: rtl/gat_bram_load_ctrl.sv
// Host-side load/readback controller for the GAT core: maps host byte writes onto per-channel
// core BRAM ports, sequences load -> start -> run -> done, and serves latency-matched readback.
module gat_bram_load_ctrl #(
  parameter int unsigned TOP_WIDTH     = 32,
  parameter int unsigned NUM_CH        = 3,
  parameter int unsigned CH_SEL_W      = $clog2(NUM_CH),
  parameter int unsigned CH_DATA_WIDTH = 19,
  parameter int unsigned CH_ADDR_W     = 18,
  parameter int unsigned CH_DEPTH      = 242101,
  parameter int unsigned FEAT_WIDTH    = 32,
  parameter int unsigned FEAT_ADDR_W   = 16,
  parameter int unsigned RD_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // host write side
  input  logic [TOP_WIDTH-1:0]     host_din,
  input  logic                     host_ena,
  input  logic                     host_wea,
  input  logic [CH_SEL_W-1:0]      host_ch_sel,
  input  logic [CH_ADDR_W+1:0]     host_addra,
  input  logic [NUM_CH-1:0]        load_done,
  input  logic                     gat_layer,
  input  logic                     clear,
  // core load side
  output logic [CH_DATA_WIDTH-1:0] core_din,
  output logic [NUM_CH-1:0]        core_ena,
  output logic [NUM_CH-1:0]        core_wea,
  output logic [CH_ADDR_W-1:0]     core_addra,
  output logic                     core_start,
  output logic                     core_layer,
  input  logic                     core_done,
  output logic                     gat_ready,
  // feature readback
  input  logic                     host_rd_req,
  input  logic [FEAT_ADDR_W+1:0]   host_rd_addr,
  output logic                     host_rd_valid,
  output logic [FEAT_WIDTH-1:0]    host_rd_data,
  output logic [FEAT_ADDR_W-1:0]   feat_bram_addrb,
  input  logic [FEAT_WIDTH-1:0]    feat_bram_dout,
  output logic [TOP_WIDTH-1:0]     gat_status
);

  localparam int unsigned DoneBits = (NUM_CH > 5) ? 5 : NUM_CH;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StStart = 3'd2,
    StRun   = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0]        done_q;
  logic                     err_misalign_q, err_range_q, err_busy_q;
  logic [15:0]              wr_cnt_q;
  logic                     core_layer_q;
  logic [NUM_CH-1:0]        core_ena_q;
  logic [CH_ADDR_W-1:0]     core_addra_q;
  logic [CH_DATA_WIDTH-1:0] core_din_q;
  logic [RD_LATENCY:0]      rd_vld_q, rd_ok_q;
  logic [FEAT_ADDR_W-1:0]   feat_addr_q;

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic                 wr_req, wr_open, wr_aligned, wr_in_range, wr_accept;
  logic [CH_ADDR_W-1:0] wr_word;
  logic [NUM_CH-1:0]    sel_oh;
  logic                 clear_done;

  assign wr_req      = host_ena & host_wea;
  assign wr_open     = (state_q == StIdle) || (state_q == StLoad);
  assign wr_aligned  = (host_addra[1:0] == 2'b00);
  assign wr_word     = host_addra[CH_ADDR_W+1:2];
  assign wr_in_range = (32'(wr_word) < CH_DEPTH) && (32'(host_ch_sel) < NUM_CH);
  assign wr_accept   = wr_req & wr_open & wr_aligned & wr_in_range;
  assign clear_done  = (state_q == StDone) & clear;

  // Out-of-range selects decode to all-zero, but such writes are never accepted anyway.
  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_oh[i] = (32'(host_ch_sel) == i);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (wr_accept || (&done_q)) state_d = StLoad;
      StLoad:  if (&done_q) state_d = StStart;
      StStart: state_d = StRun;
      StRun:   if (core_done) state_d = StDone;
      StDone:  if (clear) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      core_layer_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Latch on entry so the layer is already stable during the start pulse.
      if ((state_d == StStart) && (state_q != StStart)) begin
        core_layer_q <= gat_layer;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky done / error bits and write counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q         <= '0;
      err_misalign_q <= 1'b0;
      err_range_q    <= 1'b0;
      err_busy_q     <= 1'b0;
      wr_cnt_q       <= '0;
    end else begin
      if (clear_done) begin
        done_q <= '0;
      end else if (wr_open) begin
        done_q <= done_q | load_done;
      end
      err_misalign_q <= err_misalign_q | (wr_req & ~wr_aligned);
      err_range_q    <= err_range_q    | (wr_req & ~wr_in_range);
      err_busy_q     <= err_busy_q     | (wr_req & ~wr_open);
      if (clear_done) begin
        wr_cnt_q <= '0;
      end else if (wr_accept && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Core write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_ena_q   <= '0;
      core_addra_q <= '0;
      core_din_q   <= '0;
    end else begin
      core_ena_q <= wr_accept ? sel_oh : '0;
      if (wr_accept) begin
        core_addra_q <= wr_word;
        core_din_q   <= host_din[CH_DATA_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Feature readback: valid and "issued in DONE" travel together down a delay line
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q    <= '0;
      rd_ok_q     <= '0;
      feat_addr_q <= '0;
    end else begin
      rd_vld_q <= {rd_vld_q[RD_LATENCY-1:0], host_rd_req};
      rd_ok_q  <= {rd_ok_q[RD_LATENCY-1:0], host_rd_req & (state_q == StDone)};
      if (host_rd_req) begin
        feat_addr_q <= host_rd_addr[FEAT_ADDR_W+1:2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign core_din        = core_din_q;
  assign core_ena        = core_ena_q;
  assign core_wea        = core_ena_q;
  assign core_addra      = core_addra_q;
  assign core_start      = (state_q == StStart);
  assign core_layer      = core_layer_q;
  assign gat_ready       = (state_q == StDone);
  assign feat_bram_addrb = feat_addr_q;
  assign host_rd_valid   = rd_vld_q[RD_LATENCY];
  assign host_rd_data    = rd_ok_q[RD_LATENCY] ? feat_bram_dout : '0;

  always_comb begin
    gat_status      = '0;
    gat_status[2:0] = state_q;
    for (int unsigned i = 0; i < DoneBits; i++) begin
      gat_status[3+i] = done_q[i];
    end
    gat_status[8]     = err_misalign_q;
    gat_status[9]     = err_range_q;
    gat_status[10]    = err_busy_q;
    gat_status[31:16] = wr_cnt_q;
  end

  logic unused_bits;
  assign unused_bits = ^{host_din[TOP_WIDTH-1:CH_DATA_WIDTH], host_rd_addr[1:0]};

endmodule
